// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the memory port arbiter.
// Default widths apply when the core build does not define them.
`ifndef CPU_ADDR_BITS
`define CPU_ADDR_BITS 32
`endif
`ifndef DWIDTH
`define DWIDTH 32
`endif

package mem_port_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } owner_e;

  localparam int unsigned STARVE_LIMIT_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_pick.sv
// Winner selection for the shared memory port, with a saturating
// count of data grants taken while fetch was waiting.
module arb_starve_pick
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_valid_i,
  input  logic d_valid_i,
  input  logic grant_i,
  output logic pick_d_o
);

  localparam logic [3:0] LIM = 4'(STARVE_LIMIT);

  logic [3:0] cnt_q, cnt_d;
  logic       starved;

  assign starved  = if_valid_i && (cnt_q == LIM);
  assign pick_d_o = d_valid_i && !starved;

  always_comb begin
    cnt_d = cnt_q;
    if (grant_i) begin
      if (!pick_d_o) begin
        cnt_d = '0;
      end else if (if_valid_i && (cnt_q != LIM)) begin
        cnt_d = cnt_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and load/store; one
// transaction outstanding, fetch responses can be killed.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W       = `CPU_ADDR_BITS,
  parameter int unsigned DATA_W       = `DWIDTH,
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_valid,
  output logic                if_req_ready,
  input  logic [ADDR_W-1:0]   if_req_addr,
  input  logic                if_kill,
  output logic                if_resp_valid,
  output logic [DATA_W-1:0]   if_resp_data,
  input  logic                d_req_valid,
  output logic                d_req_ready,
  input  logic [ADDR_W-1:0]   d_req_addr,
  input  logic [DATA_W-1:0]   d_req_wdata,
  input  logic [DATA_W/8-1:0] d_req_wmask,
  output logic                d_resp_valid,
  output logic [DATA_W-1:0]   d_resp_data,
  output logic                mem_req_valid,
  input  logic                mem_req_ready,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wmask,
  input  logic                mem_resp_valid,
  input  logic [DATA_W-1:0]   mem_resp_data
);

  arb_state_e          state_q, state_d;
  owner_e              owner_q, owner_d;
  owner_e              winner;
  logic                kill_q, kill_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W/8-1:0] wmask_q, wmask_d;
  logic                pick_d, grant, idle;

  arb_starve_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk       (clk),
    .rst       (rst),
    .if_valid_i(if_req_valid),
    .d_valid_i (d_req_valid),
    .grant_i   (grant),
    .pick_d_o  (pick_d)
  );

  assign idle   = (state_q == ST_IDLE);
  assign winner = pick_d ? OWN_D : OWN_IF;

  assign if_req_ready = idle && (winner == OWN_IF) && rst;
  assign d_req_ready  = idle && (winner == OWN_D) && rst;
  assign grant = (if_req_valid && if_req_ready)
              || (d_req_valid && d_req_ready);

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    kill_d  = kill_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wmask_d = wmask_q;
    unique case (state_q)
      ST_IDLE: begin
        if (grant) begin
          state_d = ST_ISSUE;
          owner_d = winner;
          kill_d  = 1'b0;
          if (winner == OWN_D) begin
            addr_d  = d_req_addr;
            wdata_d = d_req_wdata;
            wmask_d = d_req_wmask;
          end else begin
            addr_d  = if_req_addr;
            wdata_d = '0;
            wmask_d = '0;
          end
        end
      end
      ST_ISSUE: if (mem_req_ready) state_d = ST_WAIT;
      ST_WAIT:  if (mem_resp_valid) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // A redirect only matters while a fetch is in flight.
    if (!idle && (owner_q == OWN_IF) && if_kill) begin
      kill_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      owner_q <= OWN_IF;
      kill_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      wmask_q <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      kill_q  <= kill_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      wmask_q <= wmask_d;
    end
  end

  assign mem_req_valid = (state_q == ST_ISSUE);
  assign mem_req_addr  = addr_q;
  assign mem_req_wdata = wdata_q;
  assign mem_req_wmask = wmask_q;

  assign if_resp_valid = (state_q == ST_WAIT) && (owner_q == OWN_IF)
                      && mem_resp_valid && !kill_q && !if_kill;
  assign d_resp_valid  = (state_q == ST_WAIT) && (owner_q == OWN_D)
                      && mem_resp_valid;
  assign if_resp_data  = mem_resp_data;
  assign d_resp_data   = mem_resp_data;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter (STARVE_LIMIT = 2).
// Inputs change on the falling edge; outputs are sampled 1ns later.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        if_req_valid = 1'b0;
  logic        if_req_ready;
  logic [31:0] if_req_addr = '0;
  logic        if_kill = 1'b0;
  logic        if_resp_valid;
  logic [31:0] if_resp_data;
  logic        d_req_valid = 1'b0;
  logic        d_req_ready;
  logic [31:0] d_req_addr = '0;
  logic [31:0] d_req_wdata = '0;
  logic [3:0]  d_req_wmask = '0;
  logic        d_resp_valid;
  logic [31:0] d_resp_data;
  logic        mem_req_valid;
  logic        mem_req_ready = 1'b0;
  logic [31:0] mem_req_addr;
  logic [31:0] mem_req_wdata;
  logic [3:0]  mem_req_wmask;
  logic        mem_resp_valid = 1'b0;
  logic [31:0] mem_resp_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .ADDR_W(32),
    .DATA_W(32),
    .STARVE_LIMIT(2)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .if_req_valid  (if_req_valid),
    .if_req_ready  (if_req_ready),
    .if_req_addr   (if_req_addr),
    .if_kill       (if_kill),
    .if_resp_valid (if_resp_valid),
    .if_resp_data  (if_resp_data),
    .d_req_valid   (d_req_valid),
    .d_req_ready   (d_req_ready),
    .d_req_addr    (d_req_addr),
    .d_req_wdata   (d_req_wdata),
    .d_req_wmask   (d_req_wmask),
    .d_resp_valid  (d_resp_valid),
    .d_resp_data   (d_resp_data),
    .mem_req_valid (mem_req_valid),
    .mem_req_ready (mem_req_ready),
    .mem_req_addr  (mem_req_addr),
    .mem_req_wdata (mem_req_wdata),
    .mem_req_wmask (mem_req_wmask),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data (mem_resp_data)
  );

  // Drives one full transaction with both requesters valid, starting and
  // ending just after a falling edge in IDLE; reports who was granted.
  task automatic run_both(output logic got_d, output logic resp_d);
    if_req_valid   = 1'b1;
    if_req_addr    = 32'h300;
    d_req_valid    = 1'b1;
    d_req_addr     = 32'h200;
    d_req_wmask    = 4'h0;
    mem_req_ready  = 1'b1;
    mem_resp_valid = 1'b0;
    #1 got_d = d_req_ready;
    @(negedge clk);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data  = 32'h0000_5A5A;
    #1 resp_d = d_resp_valid;
    @(negedge clk);
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b0;
    if_req_valid = 1'b1;
    d_req_valid = 1'b1;
    mem_resp_valid = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (mem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL rst_mem_req_valid got %b want 0", mem_req_valid);
    end
    n_cmp++;
    if ({if_req_ready, d_req_ready} !== 2'b00) begin
      n_bad++; $display("FAIL rst_readies got %b want 00", {if_req_ready, d_req_ready});
    end
    n_cmp++;
    if ({if_resp_valid, d_resp_valid} !== 2'b00) begin
      n_bad++; $display("FAIL rst_resp_valids got %b want 00", {if_resp_valid, d_resp_valid});
    end
    n_cmp++;
    if (mem_req_wmask !== 4'h0 || mem_req_addr !== 32'h0) begin
      n_bad++; $display("FAIL rst_captured got %h/%h want 0/0", mem_req_addr, mem_req_wmask);
    end
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
    mem_resp_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_lone_fetch;
    int pulses;
    pulses = 0;
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr = 32'h100;
    mem_req_ready = 1'b1;
    #1;
    n_cmp++;
    if (if_req_ready !== 1'b1 || d_req_ready !== 1'b0) begin
      n_bad++; $display("FAIL fetch_ready got %b%b want 10", if_req_ready, d_req_ready);
    end
    @(negedge clk);
    if_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h100 || mem_req_wmask !== 4'h0) begin
      n_bad++; $display("FAIL fetch_issue got %b %h %h want 1 100 0", mem_req_valid, mem_req_addr, mem_req_wmask);
    end
    @(negedge clk);
    #1 pulses += int'(if_resp_valid);
    @(negedge clk);
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'hDEAD_BEEF;
    #1;
    pulses += int'(if_resp_valid);
    n_cmp++;
    if (if_resp_data !== 32'hDEAD_BEEF || d_resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL fetch_resp got %h d=%b want deadbeef d=0", if_resp_data, d_resp_valid);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1 pulses += int'(if_resp_valid);
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++; $display("FAIL fetch_pulses got %0d want 1", pulses);
    end
  endtask

  task automatic test_priority;
    logic exp_d [4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic got_d, resp_d;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      run_both(got_d, resp_d);
      n_cmp++;
      if (got_d !== exp_d[i] || resp_d !== exp_d[i]) begin
        n_bad++; $display("FAIL prio_grant%0d got %b/%b want %b", i, got_d, resp_d, exp_d[i]);
      end
    end
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
  endtask

  task automatic test_store;
    @(negedge clk);
    d_req_valid = 1'b1;
    d_req_addr = 32'h400;
    d_req_wdata = 32'h1234_5678;
    d_req_wmask = 4'b0011;
    mem_req_ready = 1'b0;
    #1;
    n_cmp++;
    if (d_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL store_ready got %b want 1", d_req_ready);
    end
    @(negedge clk);
    d_req_valid = 1'b0;
    d_req_addr = 32'hFFFF_FFFF;
    d_req_wdata = 32'h0;
    d_req_wmask = 4'hF;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_req_ready = 1'b1;
      #1;
      n_cmp++;
      if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h400
          || mem_req_wdata !== 32'h1234_5678 || mem_req_wmask !== 4'b0011) begin
        n_bad++; $display("FAIL store_hold%0d got %b %h %h %b", i, mem_req_valid, mem_req_addr, mem_req_wdata, mem_req_wmask);
      end
      @(negedge clk);
    end
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    #1;
    n_cmp++;
    if (d_resp_valid !== 1'b1 || if_resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL store_ack got d=%b if=%b want 1 0", d_resp_valid, if_resp_valid);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (d_resp_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_bad++; $display("FAIL store_done got %b %b want 0 0", d_resp_valid, mem_req_valid);
    end
  endtask

  task automatic test_kill;
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr = 32'h500;
    mem_req_ready = 1'b1;
    @(negedge clk);
    if_req_valid = 1'b0;
    @(negedge clk);
    if_kill = 1'b1;
    @(negedge clk);
    if_kill = 1'b0;
    mem_resp_valid = 1'b1;
    d_req_valid = 1'b1;
    d_req_addr = 32'h540;
    d_req_wmask = 4'h0;
    #1;
    n_cmp++;
    if (if_resp_valid !== 1'b0 || d_resp_valid !== 1'b0 || d_req_ready !== 1'b0) begin
      n_bad++; $display("FAIL kill_swallow got %b %b %b want 000", if_resp_valid, d_resp_valid, d_req_ready);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1;
    n_cmp++;
    if (d_req_ready !== 1'b1) begin
      n_bad++; $display("FAIL kill_next_ready got %b want 1", d_req_ready);
    end
    @(negedge clk);
    d_req_valid = 1'b0;
    #1;
    n_cmp++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h540) begin
      n_bad++; $display("FAIL kill_next_issue got %b %h want 1 540", mem_req_valid, mem_req_addr);
    end
    @(negedge clk);
    mem_resp_valid = 1'b1;
    #1;
    n_cmp++;
    if (d_resp_valid !== 1'b1) begin
      n_bad++; $display("FAIL kill_next_resp got %b want 1", d_resp_valid);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    if_req_valid = 1'b1;
    if_req_addr = 32'h580;
    @(negedge clk);
    if_req_valid = 1'b0;
    @(negedge clk);
    if_kill = 1'b1;
    mem_resp_valid = 1'b1;
    #1;
    n_cmp++;
    if (if_resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL kill_same_cycle got %b want 0", if_resp_valid);
    end
    @(negedge clk);
    if_kill = 1'b0;
    mem_resp_valid = 1'b0;
  endtask

  task automatic test_reset_wait;
    logic exp_d [3] = '{1'b1, 1'b1, 1'b0};
    logic got_d, resp_d;
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr = 32'h600;
    d_req_valid = 1'b1;
    d_req_addr = 32'h700;
    mem_req_ready = 1'b1;
    @(negedge clk);
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++;
    if (mem_req_valid !== 1'b0 || if_req_ready !== 1'b0 || d_req_ready !== 1'b0) begin
      n_bad++; $display("FAIL rstw_outputs got %b %b %b want 000", mem_req_valid, if_req_ready, d_req_ready);
    end
    @(negedge clk);
    rst = 1'b1;
    mem_resp_valid = 1'b1;
    #1;
    n_cmp++;
    if (if_resp_valid !== 1'b0 || d_resp_valid !== 1'b0) begin
      n_bad++; $display("FAIL rstw_stray got %b %b want 00", if_resp_valid, d_resp_valid);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      run_both(got_d, resp_d);
      n_cmp++;
      if (got_d !== exp_d[i]) begin
        n_bad++; $display("FAIL rstw_grant%0d got %b want %b", i, got_d, exp_d[i]);
      end
    end
    if_req_valid = 1'b0;
    d_req_valid = 1'b0;
  endtask

  task automatic test_stray;
    int pulses;
    pulses = 0;
    @(negedge clk);
    if_req_valid = 1'b1;
    if_req_addr = 32'h800;
    mem_req_ready = 1'b0;
    @(negedge clk);
    if_req_valid = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h1111_2222;
    #1;
    n_cmp++;
    if (if_resp_valid !== 1'b0 || d_resp_valid !== 1'b0 || mem_req_valid !== 1'b1) begin
      n_bad++; $display("FAIL stray_issue got %b %b %b want 0 0 1", if_resp_valid, d_resp_valid, mem_req_valid);
    end
    @(negedge clk);
    mem_resp_valid = 1'b0;
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'hCAFE_F00D;
    #1;
    pulses += int'(if_resp_valid);
    n_cmp++;
    if (if_resp_data !== 32'hCAFE_F00D) begin
      n_bad++; $display("FAIL stray_data got %h want cafef00d", if_resp_data);
    end
    @(negedge clk);
    #1 pulses += int'(if_resp_valid);
    @(negedge clk);
    mem_resp_valid = 1'b0;
    #1 pulses += int'(if_resp_valid);
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++; $display("FAIL stray_pulses got %0d want 1", pulses);
    end
  endtask

  initial begin
    test_reset();
    test_lone_fetch();
    test_priority();
    test_store();
    test_kill();
    test_reset_wait();
    test_stray();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
